// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between a requester (control FSM)
// and mem_responder.
//   en_a   : access request strobe, sampled on each rising clk edge
//   we_a   : write qualifier, meaningful only when en_a=1
//   addr   : 16-bit word address
//   wdata  : store data
//   rdata  : registered load/fetch data
//   rvalid : one-cycle pulse marking rdata valid
// Modports: master (requester side), slave (responder side).
interface mem_responder_if #(
   parameter int unsigned DATA_W = 16
);
   logic              en_a;
   logic              we_a;
   logic [15:0]       addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;

   modport master (
      output en_a, we_a, addr, wdata,
      input  rdata, rvalid
   );

   modport slave (
      input  en_a, we_a, addr, wdata,
      output rdata, rvalid
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port word RAM with a fixed one-cycle read response,
// plus an optional small MMIO window (LED register, synchronized switches,
// free-running cycle counter).
//
// Ports:
//   clk    : single clock, all state updates on rising edge
//   reset  : synchronous, active-high reset
//   bus    : mem_responder_if.slave (en_a, we_a, addr, wdata in; rdata, rvalid out)
//   sw     : asynchronous switch inputs
//   led    : LED register
//   err    : sticky out-of-range access flag
//
// Configuration macro MEM_RESPONDER_MMIO_EN:
//   defined   : addr < DEPTH -> RAM, 0xFFF0 LED (r/w), 0xFFF1 switches (r/o),
//               0xFFF2 cycle counter (r/o), anything else out-of-range
//               (writes dropped, reads return 0, err set until reset).
//   undefined : every address maps to RAM modulo DEPTH; led and err are tied
//               to 0; no switch synchronizer or cycle counter is built.
module mem_responder #(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned DATA_W = 16
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus,
   input  logic [15:0]    sw,
   output logic [15:0]    led,
   output logic           err
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              rd_req;
   logic              wr_req;
   logic [AW-1:0]     idx;
   logic              ram_sel;
   logic [DATA_W-1:0] rd_val;

   assign rd_req = bus.en_a & ~bus.we_a;
   assign wr_req = bus.en_a & bus.we_a;
   assign idx    = bus.addr[AW-1:0];

`ifdef MEM_RESPONDER_MMIO_EN
   localparam logic [15:0] LED_ADDR = 16'hFFF0;
   localparam logic [15:0] SW_ADDR  = 16'hFFF1;
   localparam logic [15:0] CNT_ADDR = 16'hFFF2;

   logic [15:0] led_q;
   logic [15:0] sw_meta;
   logic [15:0] sw_sync;
   logic [15:0] cycle_cnt;
   logic        err_q;
   logic        is_led;
   logic        is_sw;
   logic        is_cnt;
   logic        out_of_range;

   // Address decode; DEPTH never exceeds 32768, so RAM cannot overlap MMIO.
   assign ram_sel      = {1'b0, bus.addr} < 17'(DEPTH);
   assign is_led       = (bus.addr == LED_ADDR);
   assign is_sw        = (bus.addr == SW_ADDR);
   assign is_cnt       = (bus.addr == CNT_ADDR);
   assign out_of_range = ~(ram_sel | is_led | is_sw | is_cnt);

   // Read mux; out-of-range reads return zero.
   always_comb begin
      rd_val = '0;
      if (ram_sel) begin
         rd_val = mem[idx];
      end else if (is_led) begin
         rd_val = DATA_W'(led_q);
      end else if (is_sw) begin
         rd_val = DATA_W'(sw_sync);
      end else if (is_cnt) begin
         rd_val = DATA_W'(cycle_cnt);
      end
   end

   // MMIO registers: LED, two-flop switch synchronizer, cycle counter, sticky err.
   always_ff @(posedge clk) begin
      if (reset) begin
         led_q     <= '0;
         sw_meta   <= '0;
         sw_sync   <= '0;
         cycle_cnt <= '0;
         err_q     <= 1'b0;
      end else begin
         sw_meta   <= sw;
         sw_sync   <= sw_meta;
         cycle_cnt <= cycle_cnt + 16'd1;
         if (wr_req && is_led) begin
            led_q <= 16'(bus.wdata);
         end
         if (bus.en_a && out_of_range) begin
            err_q <= 1'b1;
         end
      end
   end

   assign led = led_q;
   assign err = err_q;
`else
   logic unused_inputs;

   // Whole 16-bit space aliases onto RAM modulo DEPTH.
   assign ram_sel       = 1'b1;
   assign rd_val        = mem[idx];
   assign led           = '0;
   assign err           = 1'b0;
   assign unused_inputs = ^{sw, bus.addr[15:AW]};
`endif

   // Response FSM: RESP for exactly the cycle after each accepted read.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         bus.rdata <= '0;
      end else begin
         state <= rd_req ? RESP : IDLE;
         if (rd_req) begin
            bus.rdata <= rd_val;
         end
      end
   end

   assign bus.rvalid = (state == RESP);

   // RAM write port; contents are deliberately not touched by reset.
   always_ff @(posedge clk) begin
      if (!reset && wr_req && ram_sel) begin
         mem[idx] <= bus.wdata;
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder.
// Reads push {response cycle, expected data} into a queue; a negedge monitor
// pops and checks whenever rvalid is seen, and flags late or spurious pulses.
module tb_mem_responder;
   localparam int unsigned DEPTH  = 1024;
   localparam int unsigned DATA_W = 16;

   typedef struct {
      int unsigned cyc;
      logic [15:0] data;
      logic [15:0] addr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] sw;
   logic [15:0] led;
   logic        err;

   mem_responder_if #(.DATA_W(DATA_W)) bus ();

   mem_responder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .sw    (sw),
      .led   (led),
      .err   (err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t        q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int unsigned cyc_r = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   // Apply one sampled cycle; inputs change 1 time unit after a rising edge.
   task automatic step(input bit rst, input bit en, input bit we,
                       input logic [15:0] a, input logic [15:0] d);
      reset     = rst;
      bus.en_a  = en;
      bus.we_a  = we;
      bus.addr  = a;
      bus.wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      step(1'b0, 1'b1, 1'b1, a, d);
   endtask

   task automatic rd(input logic [15:0] a, input logic [15:0] d);
      exp_t e;
      e.cyc  = cyc + 1;
      e.data = d;
      e.addr = a;
      q.push_back(e);
      step(1'b0, 1'b1, 1'b0, a, 16'h0000);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   // Monitor: compare every rvalid pulse against the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (bus.rvalid === 1'b1) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL spurious_rvalid: got rvalid=1 rdata=%h at cycle %0d, required none", bus.rdata, cyc);
         end else begin
            e = q.pop_front();
            check($sformatf("rd_cycle_%h", e.addr), cyc, e.cyc);
            check($sformatf("rd_data_%h", e.addr), 32'(bus.rdata), 32'(e.data));
         end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL missing_rvalid_%h: got rvalid=%b at cycle %0d, required 1 data %h",
                  e.addr, bus.rvalid, cyc, e.data);
      end
   end

   initial begin
      sw = 16'h0000;
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      check("reset_rvalid", 32'(bus.rvalid), 32'd0);
      check("reset_rdata", 32'(bus.rdata), 32'd0);
      check("reset_led", 32'(led), 32'd0);
      check("reset_err", 32'(err), 32'd0);

      // Write then immediate read of the same word.
      wr(16'h0005, 16'h1234);
      rd(16'h0005, 16'h1234);

      // Three back-to-back reads: consecutive cycles enforced by cycle tags.
      wr(16'h0001, 16'hAAAA);
      wr(16'h0002, 16'hBBBB);
      wr(16'h0003, 16'hCCCC);
      rd(16'h0001, 16'hAAAA);
      rd(16'h0002, 16'hBBBB);
      rd(16'h0003, 16'hCCCC);
      idle();
      check("idle_rvalid", 32'(bus.rvalid), 32'd0);
      check("idle_rdata_hold", 32'(bus.rdata), 32'h0000CCCC);

      // we_a without en_a must not write.
      step(1'b0, 1'b0, 1'b1, 16'h0005, 16'hFFFF);
      rd(16'h0005, 16'h1234);

      // Requests sampled under reset are ignored (no write, no rvalid).
      step(1'b1, 1'b1, 1'b1, 16'h0005, 16'hBEEF);
      step(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000);
      rd(16'h0005, 16'h1234);

`ifdef MEM_RESPONDER_MMIO_EN
      wr(16'h0000, 16'h0BAD);
      wr(16'hFFF0, 16'h00FF);
      check("led_write", 32'(led), 32'h000000FF);
      rd(16'hFFF0, 16'h00FF);
      sw = 16'h5A5A;
      idle();
      idle();
      idle();
      rd(16'hFFF1, 16'h5A5A);
      wr(16'hFFF1, 16'h0000);
      rd(16'hFFF1, 16'h5A5A);
      check("err_clear_in_range", 32'(err), 32'd0);
      wr(16'h8000, 16'hDEAD);
      check("err_set_oor_write", 32'(err), 32'd1);
      rd(16'h0000, 16'h0BAD);
      rd(16'h8000, 16'h0000);
      idle();
      check("err_sticky", 32'(err), 32'd1);
`else
      // Without MMIO every address aliases modulo DEPTH.
      wr(16'h0407, 16'h7777);
      rd(16'h0007, 16'h7777);
      wr(16'h83F0, 16'h4242);
      rd(16'hFFF0, 16'h4242);
      idle();
      check("led_tied", 32'(led), 32'd0);
      check("err_tied", 32'(err), 32'd0);
`endif

      // Reset at the response edge: the pending pulse is shown, then dropped.
      rd(16'h0005, 16'h1234);
      step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      cyc_r = cyc;
      check("rst_resp_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_resp_rdata", 32'(bus.rdata), 32'd0);
      check("rst_resp_led", 32'(led), 32'd0);
      check("rst_resp_err", 32'(err), 32'd0);
      rd(16'h0005, 16'h1234);
      rd(16'h0003, 16'hCCCC);

`ifdef MEM_RESPONDER_MMIO_EN
      // Counter value at the sampling edge = non-reset edges since reset.
      repeat (65540) idle();
      rd(16'hFFF2, 16'(cyc - cyc_r));
`endif

      for (int i = 0; i < 10 && q.size() != 0; i++) idle();
      while (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout_%h: got no response, required data %h", e.addr, e.data);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 1024: number of 16-bit RAM words, power of two, maximum 32768.
REQ-002 The block SHALL have parameter DATA_W, default 16: data width; addresses are fixed at 16 bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port en_a  input  1  access request strobe from the control FSM, sampled each rising edge.
REQ-006 The block SHALL have port we_a  input  1  write qualifier; meaningful only when en_a=1.
REQ-007 The block SHALL have port addr  input  16  word address of the access.
REQ-008 The block SHALL have port wdata  input  DATA_W  store data.
REQ-009 The block SHALL have port sw  input  16  asynchronous switch inputs.
REQ-010 The block SHALL have port rdata  output  DATA_W  registered load/fetch data.
REQ-011 The block SHALL have port rvalid  output  1  pulse marking rdata valid.
REQ-012 The block SHALL have port led  output  16  LED register.
REQ-013 The block SHALL have port err  output  1  sticky flag for out-of-range accesses.

Function
REQ-014 The block SHALL run a two-state FSM: IDLE and RESP.
- Read accepted (en_a=1, we_a=0) in IDLE or RESP -> next state RESP.
- Any other cycle -> next state IDLE.
REQ-015 Read latency SHALL be exactly 1 cycle: for a read sampled at edge N, rdata and rvalid=1 are valid in the cycle after edge N, which is the requester's DOUT cycle.
REQ-016 rvalid SHALL be 1 only in RESP.
- rdata SHALL hold its last value in IDLE.
- Back-to-back reads SHALL give consecutive rvalid pulses with no bubble.
REQ-017 A write (en_a=1, we_a=1) SHALL commit at the sampling edge, produce no rvalid, and move the FSM to IDLE.
REQ-018 we_a=1 with en_a=0 SHALL be ignored.
REQ-019 A read of an address written on the previous edge SHALL return the new data.
REQ-020 Address map:
- addr < DEPTH -> RAM.
- 0xFFF0 -> LED register, read/write.
- 0xFFF1 -> synchronized sw, read-only; writes are ignored.
- 0xFFF2 -> cycle counter, read-only.
- Any other address -> out-of-range.
REQ-021 Out-of-range accesses:
- Writes SHALL be discarded.
- Reads SHALL return 0 with a normal rvalid.
- err SHALL be set to 1 and stay 1 until reset.
REQ-022 sw SHALL pass through a 2-flop synchronizer, so a read reflects sw values from at least 2 edges earlier.
REQ-023 The cycle counter SHALL be 16 bits, increment every non-reset cycle, and wrap 0xFFFF -> 0x0000.
- A read returns the count value at the sampling edge.
REQ-024 RAM contents SHALL NOT be initialized or cleared by reset.

Reset
REQ-025 While reset=1 at an edge, the block SHALL set:
- FSM to IDLE, rvalid=0, rdata=0;
- led=0, err=0;
- cycle counter=0;
- synchronizer flops=0.
REQ-026 A request sampled while reset=1 SHALL be ignored: no RAM write and no rvalid.
REQ-027 Reset asserted during RESP SHALL drop rvalid in the next cycle and discard the pending response.

Configuration
REQ-028 The block SHALL use macro MEM_RESPONDER_MMIO_EN.
- Defined: the address map of REQ-020 applies.
- Undefined: all addresses map to RAM using the address modulo DEPTH; led is tied to 0; err is tied to 0; the sw synchronizer and cycle counter are not built.

Verification
REQ-029 Write addr=0x0005 wdata=0x1234, then read 0x0005 on the next edge -> rvalid=1 one cycle later with rdata=0x1234.
REQ-030 Three back-to-back reads of 0x0001, 0x0002, 0x0003 preloaded with 0xAAAA, 0xBBBB, 0xCCCC -> rvalid high for 3 consecutive cycles with data in order.
REQ-031 With MMIO enabled, write 0xFFF0=0x00FF -> led=0x00FF; sw=0x5A5A held 3 cycles, then read 0xFFF1 -> rdata=0x5A5A.
REQ-032 With MMIO enabled, write 0x8000 (DEPTH=1024) -> err=1 and RAM unchanged; read 0x8000 -> rdata=0, rvalid=1.
REQ-033 Read issued, then reset=1 at the response edge -> rvalid=0, rdata=0, led=0; after reset, a read of the written location still returns the pre-reset data.
REQ-034 Hold 65536 cycles after reset, then read 0xFFF2 -> count value has wrapped and is consistent with 0x0000 plus the elapsed edges mod 65536.
